// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants, parser state encoding and default key codes.
package ps2_pkg;

    // Prefix bytes of the set-2 scan stream
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    // Default key codes: W/S are plain, the arrows need the E0 prefix
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    // Parser position inside a multi-byte make/break sequence
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } parser_state_t;

endpackage

// File: rtl/ps2_paddle_decoder_if.sv
// Bus between the scan-byte source and the paddle decoder.
// Handshake: key_valid is a one-cycle strobe with no back-pressure; key_data
// is only meaningful in a cycle where key_valid is high. All decoder outputs
// are level/pulse signals sampled by the consumer with no acknowledge.
interface ps2_paddle_decoder_if
    import ps2_pkg::*;
#(
    parameter int NUM_PLAYERS = 2
) ();
    logic                   key_valid;
    logic [7:0]             key_data;
    logic [NUM_PLAYERS-1:0] up;
    logic [NUM_PLAYERS-1:0] down;
    logic                   cmd_event;
    logic                   unknown_code;
    parser_state_t          parser_state;   // debug view of the parser FSM

    modport master (
        output key_valid, key_data,
        input  up, down, cmd_event, unknown_code, parser_state
    );

    modport slave (
        input  key_valid, key_data,
        output up, down, cmd_event, unknown_code, parser_state
    );
endinterface

// File: rtl/ps2_scan_parser.sv
// Set-2 byte parser: tracks E0/F0 prefixes and emits single-cycle make/break
// strobes with the final code and its extended flag. A prefix left dangling
// for PREFIX_TIMEOUT idle cycles is dropped back to IDLE.
module ps2_scan_parser
    import ps2_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 500_000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          key_valid,
    input  logic [7:0]    key_data,
    output logic          make_stb,
    output logic          break_stb,
    output logic          ext,
    output logic [7:0]    code,
    output parser_state_t state
);
    localparam int PW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PREFIX_TIMEOUT - 1);

    parser_state_t state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;

    assign state = state_q;

    // State and prefix watchdog registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, completion strobes and prefix watchdog
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        make_stb  = 1'b0;
        break_stb = 1'b0;
        ext       = 1'b0;
        code      = key_data;
        if (key_valid) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (key_data == PS2_EXT)        state_d = GOT_E0;
                    else if (key_data == PS2_BREAK) state_d = GOT_F0;
                    else                            make_stb = 1'b1;
                end
                GOT_E0: begin
                    if (key_data == PS2_BREAK)      state_d = GOT_E0F0;
                    else if (key_data != PS2_EXT) begin
                        make_stb = 1'b1;
                        ext      = 1'b1;
                        state_d  = IDLE;
                    end
                end
                GOT_F0: begin
                    // E0 after F0 is out of order but seen on real keyboards
                    if (key_data == PS2_EXT)        state_d = GOT_E0F0;
                    else if (key_data != PS2_BREAK) begin
                        break_stb = 1'b1;
                        state_d   = IDLE;
                    end
                end
                GOT_E0F0: begin
                    if (key_data != PS2_EXT && key_data != PS2_BREAK) begin
                        break_stb = 1'b1;
                        ext       = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && PREFIX_TIMEOUT != 0) begin
            if (cnt_q == P_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

endmodule

// File: rtl/ps2_paddle_decoder.sv
// Paddle decoder top: matches parser make/break events against the per-player
// key table, keeps held-key state, force-releases everything after a long idle
// stretch and produces registered up/down levels plus event pulses.
module ps2_paddle_decoder
    import ps2_pkg::*;
#(
    parameter int                       NUM_PLAYERS    = 2,
    parameter logic [8*NUM_PLAYERS-1:0] UP_CODES       = {KEY_UP, KEY_W},
    parameter logic [8*NUM_PLAYERS-1:0] DN_CODES       = {KEY_DOWN, KEY_S},
    parameter logic [NUM_PLAYERS-1:0]   UP_EXT         = 2'b10,
    parameter logic [NUM_PLAYERS-1:0]   DN_EXT         = 2'b10,
    parameter int                       HOLD_TIMEOUT   = 25_000_000,
    parameter int                       PREFIX_TIMEOUT = 500_000
) (
    input  logic                  clock,
    input  logic                  reset,
    ps2_paddle_decoder_if.slave   bus
);
    localparam int HW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_TIMEOUT - 1);

    logic                   make_stb, break_stb, ext;
    logic [7:0]             code;
    parser_state_t          pstate;

    logic [NUM_PLAYERS-1:0] match_up, match_dn;
    logic [NUM_PLAYERS-1:0] held_up_q, held_up_d, held_dn_q, held_dn_d;
    logic [NUM_PLAYERS-1:0] up_q, dn_q, up_last_q, dn_last_q;
    logic                   cmd_q, unk_q, unk_d, hold_fire;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;

    ps2_scan_parser #(
        .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
    ) u_parser (
        .clock     (clock),
        .reset     (reset),
        .key_valid (bus.key_valid),
        .key_data  (bus.key_data),
        .make_stb  (make_stb),
        .break_stb (break_stb),
        .ext       (ext),
        .code      (code),
        .state     (pstate)
    );

    // Key table lookup: every entry with matching code and prefix flag hits
    always_comb begin
        match_up = '0;
        match_dn = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            match_up[p] = (code == UP_CODES[8*p +: 8]) && (ext == UP_EXT[p]);
            match_dn[p] = (code == DN_CODES[8*p +: 8]) && (ext == DN_EXT[p]);
        end
    end

    // Held-key update and hold watchdog
    always_comb begin
        held_up_d  = held_up_q;
        held_dn_d  = held_dn_q;
        unk_d      = 1'b0;
        hold_fire  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        if (make_stb || break_stb) begin
            if ((|match_up) || (|match_dn)) begin
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (match_up[p]) held_up_d[p] = make_stb;
                    if (match_dn[p]) held_dn_d[p] = make_stb;
                end
            end else begin
                unk_d = 1'b1;
            end
        end
        if (HOLD_TIMEOUT != 0) begin
            if (bus.key_valid) begin
                hold_cnt_d = '0;
            end else if (hold_cnt_q == H_LAST) begin
                hold_fire  = 1'b1;
                hold_cnt_d = '0;
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
        // key_valid is low whenever the watchdog fires, so no make is lost
        if (hold_fire) begin
            held_up_d = '0;
            held_dn_d = '0;
        end
    end

    // Registered state and outputs; cmd_event lags the output change by one
    always_ff @(posedge clock) begin
        if (reset) begin
            held_up_q  <= '0;
            held_dn_q  <= '0;
            up_q       <= '0;
            dn_q       <= '0;
            up_last_q  <= '0;
            dn_last_q  <= '0;
            cmd_q      <= 1'b0;
            unk_q      <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            held_up_q  <= held_up_d;
            held_dn_q  <= held_dn_d;
            up_q       <= held_up_d & ~held_dn_d;
            dn_q       <= held_dn_d & ~held_up_d;
            up_last_q  <= up_q;
            dn_last_q  <= dn_q;
            cmd_q      <= (up_q != up_last_q) || (dn_q != dn_last_q);
            unk_q      <= unk_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus.up           = up_q;
    assign bus.down         = dn_q;
    assign bus.cmd_event    = cmd_q;
    assign bus.unknown_code = unk_q;
    assign bus.parser_state = pstate;

endmodule

// File: tb/tb_ps2_paddle_decoder.sv
// Directed bench for the paddle decoder with shortened watchdog timeouts.
module tb_ps2_paddle_decoder;
    import ps2_pkg::*;

    localparam int HOLD_T   = 100;
    localparam int PREFIX_T = 20;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    ps2_paddle_decoder_if #(.NUM_PLAYERS(2)) bus ();

    ps2_paddle_decoder #(
        .NUM_PLAYERS    (2),
        .HOLD_TIMEOUT   (HOLD_T),
        .PREFIX_TIMEOUT (PREFIX_T)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and global time bound
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Driver tasks: inputs change 1ns after the edge, outputs read there too
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.key_valid = 1'b1;
        bus.key_data  = b;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.key_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.up !== 2'b00) begin errors++; $display("FAIL reset_up: got %b expected 00", bus.up); end
        checks++; if (bus.down !== 2'b00) begin errors++; $display("FAIL reset_down: got %b expected 00", bus.down); end
        checks++; if (bus.cmd_event !== 1'b0 || bus.unknown_code !== 1'b0) begin errors++; $display("FAIL reset_pulses: got cmd=%b unk=%b expected 0 0", bus.cmd_event, bus.unknown_code); end
        checks++; if (bus.parser_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.parser_state, IDLE); end
    endtask

    task automatic test_make_break();
        do_reset();
        send(8'h1D);
        checks++; if (bus.up !== 2'b01 || bus.down !== 2'b00) begin errors++; $display("FAIL w_make: got up=%b down=%b expected 01 00", bus.up, bus.down); end
        checks++; if (bus.cmd_event !== 1'b0 || bus.unknown_code !== 1'b0) begin errors++; $display("FAIL w_make_pulses: got cmd=%b unk=%b expected 0 0", bus.cmd_event, bus.unknown_code); end
        tick();
        checks++; if (bus.cmd_event !== 1'b1) begin errors++; $display("FAIL w_make_event: got %b expected 1", bus.cmd_event); end
        tick();
        checks++; if (bus.cmd_event !== 1'b0) begin errors++; $display("FAIL w_make_event_end: got %b expected 0", bus.cmd_event); end
        repeat (18) tick();
        send(8'hF0);
        checks++; if (bus.up !== 2'b01 || bus.parser_state !== GOT_F0) begin errors++; $display("FAIL w_break_prefix: got up=%b state=%0d expected 01 %0d", bus.up, bus.parser_state, GOT_F0); end
        send(8'h1D);
        checks++; if (bus.up !== 2'b00) begin errors++; $display("FAIL w_break: got %b expected 00", bus.up); end
        tick();
        checks++; if (bus.cmd_event !== 1'b1) begin errors++; $display("FAIL w_break_event: got %b expected 1", bus.cmd_event); end
    endtask

    task automatic test_extended();
        do_reset();
        send(8'hE0); send(8'h75);
        checks++; if (bus.up !== 2'b10) begin errors++; $display("FAIL arrow_make: got %b expected 10", bus.up); end
        send(8'h1D);
        checks++; if (bus.up !== 2'b11) begin errors++; $display("FAIL both_up: got %b expected 11", bus.up); end
        send(8'hE0); send(8'hF0); send(8'h75);
        checks++; if (bus.up !== 2'b01) begin errors++; $display("FAIL arrow_break: got %b expected 01", bus.up); end
        send(8'h75);
        checks++; if (bus.up !== 2'b01 || bus.unknown_code !== 1'b1) begin errors++; $display("FAIL bare_75: got up=%b unk=%b expected 01 1", bus.up, bus.unknown_code); end
        send(8'hF0); send(8'hE0); send(8'h1D);
        checks++; if (bus.up !== 2'b01 || bus.unknown_code !== 1'b1) begin errors++; $display("FAIL f0e0_1d_break: got up=%b unk=%b expected 01 1", bus.up, bus.unknown_code); end
    endtask

    task automatic test_conflict();
        do_reset();
        send(8'h1D); send(8'h1B);
        checks++; if (bus.up !== 2'b00 || bus.down !== 2'b00) begin errors++; $display("FAIL ws_conflict: got up=%b down=%b expected 00 00", bus.up, bus.down); end
        send(8'h1D);
        checks++; if (bus.up !== 2'b00 || bus.down !== 2'b00) begin errors++; $display("FAIL typematic_conflict: got up=%b down=%b expected 00 00", bus.up, bus.down); end
        send(8'hF0); send(8'h1D);
        checks++; if (bus.up !== 2'b00 || bus.down !== 2'b01) begin errors++; $display("FAIL w_release: got up=%b down=%b expected 00 01", bus.up, bus.down); end
    endtask

    task automatic test_unknown_and_prefix_timeout();
        do_reset();
        send(8'h1D);
        send(8'h2C);
        checks++; if (bus.unknown_code !== 1'b1 || bus.up !== 2'b01) begin errors++; $display("FAIL unknown_2c: got unk=%b up=%b expected 1 01", bus.unknown_code, bus.up); end
        tick();
        checks++; if (bus.unknown_code !== 1'b0) begin errors++; $display("FAIL unknown_pulse_len: got %b expected 0", bus.unknown_code); end
        send(8'hE0);
        repeat (PREFIX_T - 1) tick();
        checks++; if (bus.parser_state !== GOT_E0) begin errors++; $display("FAIL prefix_alive: got %0d expected %0d", bus.parser_state, GOT_E0); end
        tick();
        checks++; if (bus.parser_state !== IDLE) begin errors++; $display("FAIL prefix_expired: got %0d expected %0d", bus.parser_state, IDLE); end
        send(8'h75);
        checks++; if (bus.unknown_code !== 1'b1 || bus.up !== 2'b01) begin errors++; $display("FAIL stale_prefix_75: got unk=%b up=%b expected 1 01", bus.unknown_code, bus.up); end
    endtask

    task automatic test_hold_timeout();
        do_reset();
        send(8'hE0); send(8'h72);
        checks++; if (bus.down !== 2'b10) begin errors++; $display("FAIL arrow_down_make: got %b expected 10", bus.down); end
        repeat (HOLD_T - 1) tick();
        checks++; if (bus.down !== 2'b10) begin errors++; $display("FAIL hold_before_timeout: got %b expected 10", bus.down); end
        tick();
        checks++; if (bus.down !== 2'b00) begin errors++; $display("FAIL hold_released: got %b expected 00", bus.down); end
        do_reset();
        send(8'hE0); send(8'h72);
        for (int r = 0; r < 3; r++) begin
            repeat (50) tick();
            send(8'hE0); send(8'h72);
        end
        repeat (60) tick();
        checks++; if (bus.down !== 2'b10) begin errors++; $display("FAIL typematic_keepalive: got %b expected 10", bus.down); end
    endtask

    task automatic test_back_to_back_reset();
        do_reset();
        send(8'h1D);
        send(8'hE0); send(8'hF0);
        checks++; if (bus.parser_state !== GOT_E0F0 || bus.up !== 2'b01) begin errors++; $display("FAIL pre_reset: got state=%0d up=%b expected %0d 01", bus.parser_state, bus.up, GOT_E0F0); end
        reset = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_data  = 8'h75;
        tick();
        reset = 1'b0;
        bus.key_valid = 1'b0;
        checks++; if (bus.up !== 2'b00 || bus.down !== 2'b00 || bus.parser_state !== IDLE) begin errors++; $display("FAIL reset_with_valid: got up=%b down=%b state=%0d expected 00 00 %0d", bus.up, bus.down, bus.parser_state, IDLE); end
        send(8'h75);
        checks++; if (bus.up !== 2'b00 || bus.unknown_code !== 1'b1) begin errors++; $display("FAIL post_reset_75: got up=%b unk=%b expected 00 1", bus.up, bus.unknown_code); end
    endtask

    // Test sequence and final report
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_data  = 8'h00;
        test_reset();
        test_make_break();
        test_extended();
        test_conflict();
        test_unknown_and_prefix_timeout();
        test_hold_timeout();
        test_back_to_back_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
